irq_ack_dispatcher: RTL and testbench

- Sequential back end for the 27-channel priority interrupt encoder: 3 request buses (A, B, C) × 9 channels.
- Latches incoming request pulses into pending registers and drives them to the encoder.
- Samples the encoder's grant (bus flags + channel index) and decodes it back to one channel.
- Presents that channel to the CPU with a valid/ready handshake, pulses a one-hot acknowledge, then clears the pending bit.

---
 rtl/irq_ack_pkg.sv | 35 +++
 rtl/irq_grant_decode.sv | 63 ++++++
 rtl/irq_ack_dispatcher.sv | 184 ++++++++++++++++++
 tb/tb_irq_ack_dispatcher.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ack_pkg.sv
// Shared types and helpers for the interrupt acknowledge dispatcher.
// Holds the FSM state encoding, the bus numbering presented to the CPU,
// and the grant shape check used by the grant decoder.
package irq_ack_pkg;

    localparam int NCH_DEF = 9;

    localparam logic [1:0] BUS_A = 2'd0;
    localparam logic [1:0] BUS_B = 2'd1;
    localparam logic [1:0] BUS_C = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_SAMPLE  = 3'd2,
        ST_PRESENT = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    // A grant is well formed when exactly one bus flag is raised and the
    // channel index fits inside the bus; the pending-bit check is done by
    // the caller once the index is known to be safe.
    function automatic logic grant_shape_ok(
        input logic       pa,
        input logic       pb,
        input logic       pc,
        input logic [3:0] chan,
        input logic [3:0] max_chan
    );
        logic exactly_one;
        exactly_one = (pa ^ pb ^ pc) & ~(pa & pb & pc);
        return exactly_one && (chan <= max_chan);
    endfunction

endpackage

// File: rtl/irq_grant_decode.sv
// Combinational decode of the encoder grant back to a single channel.
// Produces a validity flag, the winning bus number and a one-hot clear
// vector laid out as {C, B, A}, each NCH bits wide. The channel index is
// turned into a one-hot mask by comparison, so an out-of-range index can
// never select a bit of the pending or clear vectors.
module irq_grant_decode
    import irq_ack_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic             gnt_pa_i,
    input  logic             gnt_pb_i,
    input  logic             gnt_pc_i,
    input  logic [3:0]       gnt_chan_i,
    input  logic [NCH-1:0]   pend_a_i,
    input  logic [NCH-1:0]   pend_b_i,
    input  logic [NCH-1:0]   pend_c_i,
    output logic             valid_o,
    output logic [1:0]       bus_o,
    output logic [3*NCH-1:0] clr_o
);

    localparam logic [3:0] MAX_CHAN = 4'(NCH - 1);

    logic [NCH-1:0] chan_oh;
    logic           shape_ok;

    // Validate the grant and build the one-hot clear for the winning channel.
    always_comb begin
        chan_oh  = '0;
        valid_o  = 1'b0;
        bus_o    = BUS_A;
        clr_o    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gnt_chan_i == 4'(i)) begin
                chan_oh[i] = 1'b1;
            end
        end
        shape_ok = grant_shape_ok(gnt_pa_i, gnt_pb_i, gnt_pc_i, gnt_chan_i, MAX_CHAN);
        if (shape_ok) begin
            if (gnt_pa_i) begin
                bus_o = BUS_A;
                if (|(chan_oh & pend_a_i)) begin
                    valid_o          = 1'b1;
                    clr_o[NCH-1:0]   = chan_oh;
                end
            end else if (gnt_pb_i) begin
                bus_o = BUS_B;
                if (|(chan_oh & pend_b_i)) begin
                    valid_o              = 1'b1;
                    clr_o[2*NCH-1:NCH]   = chan_oh;
                end
            end else begin
                bus_o = BUS_C;
                if (|(chan_oh & pend_c_i)) begin
                    valid_o                = 1'b1;
                    clr_o[3*NCH-1:2*NCH]   = chan_oh;
                end
            end
        end
    end

endmodule

// File: rtl/irq_ack_dispatcher.sv
// Sequential back end for the 27-channel priority interrupt encoder.
// Latches request pulses into pending bits, waits for the external
// combinational encoder to settle, samples and validates its grant, offers
// the winner to the CPU over valid/ready and finally pulses a one-hot ack
// that also clears the pending bit (a same-cycle re-request survives).
// Optional build macro IRQ_GRANT_ERR_EN adds a sticky grant_err flag and a
// saturating 8-bit err_cnt of rejected grants.
module irq_ack_dispatcher
    import irq_ack_pkg::*;
#(
    parameter int NCH    = NCH_DEF,
    parameter int SETTLE = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req_a,
    input  logic [NCH-1:0] req_b,
    input  logic [NCH-1:0] req_c,
    output logic [NCH-1:0] pend_a,
    output logic [NCH-1:0] pend_b,
    output logic [NCH-1:0] pend_c,
    input  logic           gnt_pa,
    input  logic           gnt_pb,
    input  logic           gnt_pc,
    input  logic [3:0]     gnt_chan,
    output logic           irq_valid,
    input  logic           irq_ready,
    output logic [1:0]     irq_bus,
    output logic [3:0]     irq_chan,
    output logic [NCH-1:0] ack_a,
    output logic [NCH-1:0] ack_b,
    output logic [NCH-1:0] ack_c
`ifdef IRQ_GRANT_ERR_EN
    ,
    output logic           grant_err,
    output logic [7:0]     err_cnt
`endif
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t           state_q;
    logic [3:0]       cnt_q;
    logic [NCH-1:0]   pend_a_q, pend_b_q, pend_c_q;
    logic [NCH-1:0]   pend_a_d, pend_b_d, pend_c_d;
    logic             irq_valid_q;
    logic [1:0]       irq_bus_q;
    logic [3:0]       irq_chan_q;
    logic [3*NCH-1:0] sel_q;
    logic [3*NCH-1:0] ack_q;

    logic             dec_valid;
    logic [1:0]       dec_bus;
    logic [3*NCH-1:0] dec_clr;
    logic             any_pend;
    logic             any_req;

`ifdef IRQ_GRANT_ERR_EN
    logic             grant_err_q;
    logic [7:0]       err_cnt_q;
`endif

    irq_grant_decode #(
        .NCH (NCH)
    ) u_decode (
        .gnt_pa_i   (gnt_pa),
        .gnt_pb_i   (gnt_pb),
        .gnt_pc_i   (gnt_pc),
        .gnt_chan_i (gnt_chan),
        .pend_a_i   (pend_a_q),
        .pend_b_i   (pend_b_q),
        .pend_c_i   (pend_c_q),
        .valid_o    (dec_valid),
        .bus_o      (dec_bus),
        .clr_o      (dec_clr)
    );

    assign any_pend = |{pend_a_q, pend_b_q, pend_c_q};
    assign any_req  = |{req_a, req_b, req_c};

    // Next pending state: the ack vector doubles as the clear, and a new
    // request on the same bit wins so a re-request during ACK is kept.
    always_comb begin
        pend_a_d = (pend_a_q & ~ack_q[NCH-1:0])       | req_a;
        pend_b_d = (pend_b_q & ~ack_q[2*NCH-1:NCH])   | req_b;
        pend_c_d = (pend_c_q & ~ack_q[3*NCH-1:2*NCH]) | req_c;
    end

    // Pending registers feeding the external encoder.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_a_q <= '0;
            pend_b_q <= '0;
            pend_c_q <= '0;
        end else begin
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            pend_c_q <= pend_c_d;
        end
    end

    // Dispatch FSM: settle, sample the grant, present to the CPU, acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            irq_valid_q <= 1'b0;
            irq_bus_q   <= BUS_A;
            irq_chan_q  <= 4'd0;
            sel_q       <= '0;
            ack_q       <= '0;
`ifdef IRQ_GRANT_ERR_EN
            grant_err_q <= 1'b0;
            err_cnt_q   <= 8'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_pend) begin
                        cnt_q   <= SETTLE_LD;
                        state_q <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (any_req) begin
                        cnt_q <= SETTLE_LD;
                    end else if (cnt_q <= 4'd1) begin
                        cnt_q   <= 4'd0;
                        state_q <= ST_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_SAMPLE: begin
                    if (dec_valid) begin
                        irq_valid_q <= 1'b1;
                        irq_bus_q   <= dec_bus;
                        irq_chan_q  <= gnt_chan;
                        sel_q       <= dec_clr;
                        state_q     <= ST_PRESENT;
                    end else begin
                        state_q     <= ST_IDLE;
`ifdef IRQ_GRANT_ERR_EN
                        grant_err_q <= 1'b1;
                        if (err_cnt_q != 8'hFF) begin
                            err_cnt_q <= err_cnt_q + 8'd1;
                        end
`endif
                    end
                end
                ST_PRESENT: begin
                    if (irq_ready) begin
                        irq_valid_q <= 1'b0;
                        ack_q       <= sel_q;
                        state_q     <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    ack_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign pend_a    = pend_a_q;
    assign pend_b    = pend_b_q;
    assign pend_c    = pend_c_q;
    assign irq_valid = irq_valid_q;
    assign irq_bus   = irq_bus_q;
    assign irq_chan  = irq_chan_q;
    assign ack_a     = ack_q[NCH-1:0];
    assign ack_b     = ack_q[2*NCH-1:NCH];
    assign ack_c     = ack_q[3*NCH-1:2*NCH];

`ifdef IRQ_GRANT_ERR_EN
    assign grant_err = grant_err_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_irq_ack_dispatcher.sv
// Self-checking bench for irq_ack_dispatcher with a behavioural priority
// encoder (lowest channel of A, then B, then C) that can be overridden to
// inject malformed grants. Expected presentations and acks are queued when
// requests are driven and popped by a monitor when the DUT produces them.
module tb_irq_ack_dispatcher;
    import irq_ack_pkg::*;

    localparam int NCH    = 9;
    localparam int SETTLE = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] req_a, req_b, req_c;
    logic [NCH-1:0] pend_a, pend_b, pend_c;
    logic           gnt_pa, gnt_pb, gnt_pc;
    logic [3:0]     gnt_chan;
    logic           irq_valid, irq_ready;
    logic [1:0]     irq_bus;
    logic [3:0]     irq_chan;
    logic [NCH-1:0] ack_a, ack_b, ack_c;
`ifdef IRQ_GRANT_ERR_EN
    logic           grant_err;
    logic [7:0]     err_cnt;
`endif

    logic           ovr, ovrPa, ovrPb, ovrPc;
    logic [3:0]     ovrChan;
    logic           mPa, mPb, mPc;
    logic [3:0]     mChan;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ackSeen = 0;
    bit prevValid = 1'b0;

    typedef struct packed {
        logic [1:0] bus;
        logic [3:0] chan;
    } pres_t;

    typedef struct {
        logic [1:0]  reqBus;
        logic [3:0]  reqChan;
        int          delay;
        logic [1:0]  expBus;
        logic [3:0]  expChan;
        logic [26:0] expAck;
    } vec_t;

    pres_t       presQ[$];
    logic [26:0] ackQ[$];
    vec_t        vecs[6];

    logic [26:0] ackVec;
    assign ackVec = {ack_c, ack_b, ack_a};

    irq_ack_dispatcher #(
        .NCH    (NCH),
        .SETTLE (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .pend_a    (pend_a),
        .pend_b    (pend_b),
        .pend_c    (pend_c),
        .gnt_pa    (gnt_pa),
        .gnt_pb    (gnt_pb),
        .gnt_pc    (gnt_pc),
        .gnt_chan  (gnt_chan),
        .irq_valid (irq_valid),
        .irq_ready (irq_ready),
        .irq_bus   (irq_bus),
        .irq_chan  (irq_chan),
        .ack_a     (ack_a),
        .ack_b     (ack_b),
        .ack_c     (ack_c)
`ifdef IRQ_GRANT_ERR_EN
        ,
        .grant_err (grant_err),
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [3:0] lowestSet(input logic [NCH-1:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Reference encoder: lowest pending channel on A, then B, then C.
    always_comb begin
        mPa = 1'b0; mPb = 1'b0; mPc = 1'b0; mChan = 4'd0;
        if (|pend_a) begin
            mPa = 1'b1; mChan = lowestSet(pend_a);
        end else if (|pend_b) begin
            mPb = 1'b1; mChan = lowestSet(pend_b);
        end else if (|pend_c) begin
            mPc = 1'b1; mChan = lowestSet(pend_c);
        end
        gnt_pa   = ovr ? ovrPa   : mPa;
        gnt_pb   = ovr ? ovrPb   : mPb;
        gnt_pc   = ovr ? ovrPc   : mPc;
        gnt_chan = ovr ? ovrChan : mChan;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare each new presentation and each ack pulse with the queues.
    always @(negedge clk) begin
        pres_t p;
        if (!rst) begin
            if (irq_valid && !prevValid) begin
                if (presQ.size() == 0) begin
                    checkOutput("unexpected_present", 32'(irq_valid), 32'd0);
                end else begin
                    p = presQ.pop_front();
                    checkOutput("present_bus", 32'(irq_bus), 32'(p.bus));
                    checkOutput("present_chan", 32'(irq_chan), 32'(p.chan));
                end
            end
            if (ackVec != '0) begin
                ackSeen++;
                if (ackQ.size() == 0) begin
                    checkOutput("unexpected_ack", 32'(ackVec), 32'd0);
                end else begin
                    checkOutput("ack_vec", 32'(ackVec), 32'(ackQ.pop_front()));
                end
            end
        end
        prevValid = irq_valid;
    end

    task automatic driveReq(input logic [NCH-1:0] a, input logic [NCH-1:0] b,
                            input logic [NCH-1:0] c, output int c0);
        @(posedge clk); #1;
        c0 = cyc;
        req_a = a; req_b = b; req_c = c;
        @(posedge clk); #1;
        req_a = '0; req_b = '0; req_c = '0;
    endtask

    task automatic applyStimulus(input vec_t v, output int c0);
        logic [NCH-1:0] oh;
        pres_t p;
        oh = 9'(1) << v.reqChan;
        p.bus  = v.expBus;
        p.chan = v.expChan;
        presQ.push_back(p);
        ackQ.push_back(v.expAck);
        case (v.reqBus)
            BUS_A:   driveReq(oh, '0, '0, c0);
            BUS_B:   driveReq('0, oh, '0, c0);
            default: driveReq('0, '0, oh, c0);
        endcase
    endtask

    task automatic waitValid(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (irq_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("valid_timeout", 32'(irq_valid), 32'd1);
    endtask

    task automatic waitDrain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (presQ.size() == 0 && ackQ.size() == 0 && !irq_valid && ackVec == '0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("drain_timeout", 32'(presQ.size() + ackQ.size()), 32'd0);
    endtask

    initial begin
        int c0;
        int ackBefore;
        logic [7:0] e0;

        vecs[0] = '{BUS_B, 4'd4,  0, BUS_B, 4'd4, 27'h0002000};
        vecs[1] = '{BUS_A, 4'd0, 20, BUS_A, 4'd0, 27'h0000001};
        vecs[2] = '{BUS_C, 4'd8,  3, BUS_C, 4'd8, 27'h4000000};
        vecs[3] = '{BUS_A, 4'd8,  1, BUS_A, 4'd8, 27'h0000100};
        vecs[4] = '{BUS_C, 4'd5,  0, BUS_C, 4'd5, 27'h0800000};
        vecs[5] = '{BUS_B, 4'd0,  2, BUS_B, 4'd0, 27'h0000200};

        rst = 1'b1; irq_ready = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        ovr = 1'b0; ovrPa = 1'b0; ovrPb = 1'b0; ovrPc = 1'b0; ovrChan = 4'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_valid", 32'(irq_valid), 32'd0);
        checkOutput("reset_bus", 32'(irq_bus), 32'd0);
        checkOutput("reset_chan", 32'(irq_chan), 32'd0);
        checkOutput("reset_pend", 32'({pend_c, pend_b, pend_a}), 32'd0);
        checkOutput("reset_ack", 32'(ackVec), 32'd0);
`ifdef IRQ_GRANT_ERR_EN
        checkOutput("reset_grant_err", 32'(grant_err), 32'd0);
        checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
`endif

        // Table-driven single requests, including the 20-cycle backpressure case.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k], c0);
            waitValid(40);
            checkOutput("latency", 32'(cyc), 32'(c0 + 3 + SETTLE));
            for (int d = 0; d < vecs[k].delay; d++) begin
                @(negedge clk);
                checkOutput("hold_valid", 32'(irq_valid), 32'd1);
                checkOutput("hold_bus", 32'(irq_bus), 32'(vecs[k].expBus));
                checkOutput("hold_chan", 32'(irq_chan), 32'(vecs[k].expChan));
                checkOutput("hold_no_ack", 32'(ackVec), 32'd0);
            end
            @(posedge clk); #1 irq_ready = 1'b1;
            @(posedge clk); #1 irq_ready = 1'b0;
            @(negedge clk);
            checkOutput("valid_drop", 32'(irq_valid), 32'd0);
            checkOutput("ack_after_hs", 32'(ackVec), 32'(vecs[k].expAck));
            @(negedge clk);
            checkOutput("pend_cleared", 32'({pend_c, pend_b, pend_a}), 32'd0);
            checkOutput("ack_one_cycle", 32'(ackVec), 32'd0);
        end

        // Two pendings: A0 wins first, C8 follows; each acked exactly once.
        begin
            pres_t p;
            ackBefore = ackSeen;
            p.bus = BUS_A; p.chan = 4'd0; presQ.push_back(p); ackQ.push_back(27'h0000001);
            p.bus = BUS_C; p.chan = 4'd8; presQ.push_back(p); ackQ.push_back(27'h4000000);
            irq_ready = 1'b1;
            driveReq(9'h001, 9'h000, 9'h100, c0);
            waitDrain(80);
            irq_ready = 1'b0;
            repeat (8) @(negedge clk);
            checkOutput("two_pend_acks", 32'(ackSeen - ackBefore), 32'd2);
        end

        // Collision: re-request A3 during its own ack cycle keeps it pending.
        begin
            pres_t p;
            p.bus = BUS_A; p.chan = 4'd3;
            presQ.push_back(p); ackQ.push_back(27'h0000008);
            presQ.push_back(p); ackQ.push_back(27'h0000008);
            driveReq(9'h008, 9'h000, 9'h000, c0);
            waitValid(40);
            @(posedge clk); #1 irq_ready = 1'b1;
            @(posedge clk); #1 irq_ready = 1'b0; req_a = 9'h008;
            @(posedge clk); #1 req_a = '0;
            @(negedge clk);
            checkOutput("collision_pend", 32'(pend_a), 32'h008);
            waitValid(40);
            checkOutput("collision_rechan", 32'(irq_chan), 32'd3);
            irq_ready = 1'b1;
            waitDrain(40);
            irq_ready = 1'b0;
        end

        // Bad grant: two bus flags and channel 11 must be rejected.
        begin
            pres_t p;
            ackBefore = ackSeen;
            ovr = 1'b1; ovrPa = 1'b1; ovrPb = 1'b1; ovrPc = 1'b0; ovrChan = 4'd11;
            irq_ready = 1'b1;
            driveReq(9'h001, 9'h000, 9'h000, c0);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                checkOutput("bad_no_valid", 32'(irq_valid), 32'd0);
            end
            checkOutput("bad_no_ack", 32'(ackSeen - ackBefore), 32'd0);
`ifdef IRQ_GRANT_ERR_EN
            checkOutput("grant_err_set", 32'(grant_err), 32'd1);
            e0 = err_cnt;
            checkOutput("err_cnt_nonzero", 32'(e0 != 8'd0), 32'd1);
            repeat (4) @(negedge clk);
            checkOutput("err_cnt_step", 32'(err_cnt), 32'(e0 + 8'd1));
`endif
            p.bus = BUS_A; p.chan = 4'd0;
            presQ.push_back(p); ackQ.push_back(27'h0000001);
            @(posedge clk); #1 ovr = 1'b0;
            waitDrain(40);
            irq_ready = 1'b0;
        end

        // Reset while presenting: everything clears and no ack ever appears.
        begin
            pres_t p;
            p.bus = BUS_B; p.chan = 4'd2;
            presQ.push_back(p);
            driveReq(9'h000, 9'h004, 9'h000, c0);
            waitValid(40);
            ackBefore = ackSeen;
            @(posedge clk); #1 rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            @(negedge clk);
            checkOutput("rst_mid_valid", 32'(irq_valid), 32'd0);
            checkOutput("rst_mid_bus", 32'(irq_bus), 32'd0);
            checkOutput("rst_mid_chan", 32'(irq_chan), 32'd0);
            checkOutput("rst_mid_pend", 32'({pend_c, pend_b, pend_a}), 32'd0);
            checkOutput("rst_mid_ack", 32'(ackVec), 32'd0);
`ifdef IRQ_GRANT_ERR_EN
            checkOutput("rst_mid_grant_err", 32'(grant_err), 32'd0);
`endif
            irq_ready = 1'b1;
            repeat (15) @(negedge clk);
            irq_ready = 1'b0;
            checkOutput("rst_mid_no_ack", 32'(ackSeen - ackBefore), 32'd0);
        end

        checkOutput("pres_queue_empty", 32'(presQ.size()), 32'd0);
        checkOutput("ack_queue_empty", 32'(ackQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
